// File: rtl/vga_pkg.sv
// Shared types, colour-bar constants and timing helpers for the VGA timing generator.
//   rgb_t        : 24-bit pixel {r,g,b}
//   vga_stage_t  : one slot of the sync/active delay pipeline
//   timing_total : sums active + porches + sync for one axis
//   bar_colour   : maps a bar index 0..7 to its test-pattern colour
package vga_pkg;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } vga_stage_t;

    localparam rgb_t BAR_WHITE   = 24'hFF_FF_FF;
    localparam rgb_t BAR_YELLOW  = 24'hFF_FF_00;
    localparam rgb_t BAR_CYAN    = 24'h00_FF_FF;
    localparam rgb_t BAR_GREEN   = 24'h00_FF_00;
    localparam rgb_t BAR_MAGENTA = 24'hFF_00_FF;
    localparam rgb_t BAR_RED     = 24'hFF_00_00;
    localparam rgb_t BAR_BLUE    = 24'h00_00_FF;
    localparam rgb_t BAR_BLACK   = 24'h00_00_00;

    // Total period of one axis in pixels (horizontal) or lines (vertical).
    function automatic int unsigned timing_total(input int unsigned active,
                                                 input int unsigned fp,
                                                 input int unsigned sync,
                                                 input int unsigned bp);
        return active + fp + sync + bp;
    endfunction

    // Colour of each of the eight vertical bars, left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-fetch bus between the timing generator and a pixel source.
//   o_req        : pixel request (combinational, master -> slave)
//   o_x, o_y     : requested column/row, zero outside the active area
//   o_sof        : start-of-frame pulse
//   i_rgb        : pixel data returned PIX_LAT enabled cycles after o_req
interface vga_timing_gen_if #(
    parameter int unsigned COORD_W = 10
);
    import vga_pkg::*;

    logic               o_req;
    logic [COORD_W-1:0] o_x;
    logic [COORD_W-1:0] o_y;
    logic               o_sof;
    rgb_t               i_rgb;

    modport master (output o_req, output o_x, output o_y, output o_sof, input i_rgb);
    modport slave  (input o_req, input o_x, input o_y, input o_sof, output i_rgb);

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter plus sync window and active flag.
//   clk, rst  : clock, synchronous active-high reset
//   step      : advance the count this cycle
//   cnt       : current position (registered)
//   wrap_c    : step on the last position (combinational)
//   sync_c    : raw sync level, SYNC_POL inside the sync window (combinational)
//   active_c  : position lies in the visible region (combinational)
module vga_axis_counter
    import vga_pkg::*;
#(
    parameter int unsigned ACTIVE   = 640,
    parameter int unsigned FP       = 16,
    parameter int unsigned SYNC     = 96,
    parameter int unsigned BP       = 48,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned W        = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         step,
    output logic [W-1:0] cnt,
    output logic         wrap_c,
    output logic         sync_c,
    output logic         active_c
);

    localparam int unsigned  TOTAL      = timing_total(ACTIVE, FP, SYNC, BP);
    localparam logic [W-1:0] LAST       = W'(TOTAL - 1);
    localparam logic [W-1:0] ACT_END    = W'(ACTIVE);
    localparam logic [W-1:0] SYNC_START = W'(ACTIVE + FP);
    localparam logic [W-1:0] SYNC_END   = W'(ACTIVE + FP + SYNC);

    // Position counter, wraps to zero after the last position.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (step) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    // Decodes of the current position.
    always_comb begin
        wrap_c   = step && (cnt == LAST);
        active_c = (cnt < ACT_END);
        sync_c   = ((cnt >= SYNC_START) && (cnt < SYNC_END)) ? SYNC_POL : ~SYNC_POL;
    end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pixel-fetch port and delay-matched DAC outputs.
//   clk, rst        : clock, synchronous active-high reset
//   i_en            : pixel-clock enable; everything holds when low
//   pix (master)    : o_req/o_x/o_y/o_sof requests, i_rgb returns PIX_LAT enabled cycles later
//   o_vga_r/g/b     : registered colour, zero outside the active area
//   o_vga_hs/vs     : sync, delayed PIX_LAT+1 enabled cycles behind the counters
//   o_vga_blank     : active-low blank (high while visible)
//   o_vga_sync      : composite sync, tied low
//   o_vga_clk       : DAC clock, inverted clk
// Build option: define VGA_TEST_PATTERN_EN to replace i_rgb with eight colour bars.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0,
    parameter int unsigned PIX_LAT  = 2,
    parameter int unsigned COORD_W  = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    vga_timing_gen_if.master pix,
    output logic [7:0]       o_vga_r,
    output logic [7:0]       o_vga_g,
    output logic [7:0]       o_vga_b,
    output logic             o_vga_hs,
    output logic             o_vga_vs,
    output logic             o_vga_blank,
    output logic             o_vga_sync,
    output logic             o_vga_clk
);

    localparam int unsigned DEPTH      = PIX_LAT + 1;
    localparam vga_stage_t  IDLE_STAGE = '{hs: ~SYNC_POL, vs: ~SYNC_POL, active: 1'b0};

    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic               h_wrap_c;
    logic               v_wrap_unused_c;
    logic               hs_raw_c;
    logic               vs_raw_c;
    logic               h_act_c;
    logic               v_act_c;
    logic               active_c;

    vga_stage_t pipe_q [DEPTH];
    vga_stage_t tap    [DEPTH + 1];
    rgb_t       src_rgb_c;
    rgb_t       rgb_q;

    vga_axis_counter #(
        .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
        .SYNC_POL(SYNC_POL), .W(COORD_W)
    ) u_h_axis (
        .clk(clk), .rst(rst), .step(i_en),
        .cnt(h_cnt), .wrap_c(h_wrap_c), .sync_c(hs_raw_c), .active_c(h_act_c)
    );

    vga_axis_counter #(
        .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
        .SYNC_POL(SYNC_POL), .W(COORD_W)
    ) u_v_axis (
        .clk(clk), .rst(rst), .step(h_wrap_c),
        .cnt(v_cnt), .wrap_c(v_wrap_unused_c), .sync_c(vs_raw_c), .active_c(v_act_c)
    );

    // Request port, driven straight from the counter stage.
    always_comb begin
        active_c  = h_act_c && v_act_c;
        pix.o_req = active_c && i_en;
        pix.o_x   = active_c ? h_cnt : '0;
        pix.o_y   = active_c ? v_cnt : '0;
        pix.o_sof = i_en && (h_cnt == '0) && (v_cnt == '0);
    end

    // tap[0] is the undelayed counter stage, tap[i+1] is pipeline stage i.
    always_comb begin
        tap[0] = '{hs: hs_raw_c, vs: vs_raw_c, active: active_c};
        for (int unsigned i = 0; i < DEPTH; i++) begin
            tap[i + 1] = pipe_q[i];
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // Bar index travels alongside the request so the pattern lands with PIX_LAT latency.
    localparam int unsigned BAR_W     = (H_ACTIVE >= 8) ? H_ACTIVE / 8 : 1;
    localparam int unsigned BAR_DEPTH = (PIX_LAT == 0) ? 1 : PIX_LAT;

    logic [2:0]  bar_q   [BAR_DEPTH];
    logic [2:0]  bar_tap [PIX_LAT + 1];
    int unsigned bar_idx_c;
    logic        unused_rgb_c;

    assign unused_rgb_c = ^pix.i_rgb;

    always_comb begin
        bar_idx_c  = 32'(h_cnt) / BAR_W;
        bar_tap[0] = (bar_idx_c > 7) ? 3'd7 : 3'(bar_idx_c);
        for (int unsigned i = 1; i <= PIX_LAT; i++) begin
            bar_tap[i] = bar_q[i - 1];
        end
        src_rgb_c = bar_colour(bar_tap[PIX_LAT]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BAR_DEPTH; i++) begin
                bar_q[i] <= 3'd0;
            end
        end else if (i_en) begin
            for (int unsigned i = 0; i < PIX_LAT; i++) begin
                bar_q[i] <= bar_tap[i];
            end
        end
    end
`else
    assign src_rgb_c = pix.i_rgb;
`endif

    // Sync/active delay line and colour register; colour is gated by the active
    // flag of the request that the returning pixel belongs to (tap PIX_LAT).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= IDLE_STAGE;
            end
            rgb_q <= '0;
        end else if (i_en) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pipe_q[i] <= tap[i];
            end
            rgb_q <= tap[PIX_LAT].active ? src_rgb_c : '0;
        end
    end

    assign o_vga_hs    = pipe_q[PIX_LAT].hs;
    assign o_vga_vs    = pipe_q[PIX_LAT].vs;
    assign o_vga_blank = pipe_q[PIX_LAT].active;
    assign o_vga_r     = rgb_q.r;
    assign o_vga_g     = rgb_q.g;
    assign o_vga_b     = rgb_q.b;
    assign o_vga_sync  = 1'b0;
    assign o_vga_clk   = ~clk;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen on a 16x8 raster (H 8/2/3/3, V 4/1/2/1,
// PIX_LAT=2). The driver pushes the expected outputs of each cycle; a monitor on
// the falling edge pops and compares.
module tb_vga_timing_gen;

    localparam int unsigned CW = 4;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        blank;
        logic [23:0] rgb;
        logic        req;
        logic [3:0]  x;
        logic [3:0]  y;
        logic        sof;
        logic        sync;
        logic        vclk;
    } obs_t;

    typedef struct {
        obs_t o;
        int   k;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_en;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_blank, vga_sync, vga_clk;

    vga_timing_gen_if #(.COORD_W(CW)) pix ();

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b0), .PIX_LAT(2), .COORD_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .i_en(i_en), .pix(pix),
        .o_vga_r(vga_r), .o_vga_g(vga_g), .o_vga_b(vga_b),
        .o_vga_hs(vga_hs), .o_vga_vs(vga_vs), .o_vga_blank(vga_blank),
        .o_vga_sync(vga_sync), .o_vga_clk(vga_clk)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   vectors     = 0;
    int   miscompares = 0;
    int   k           = 0;    // enabled edges since the last reset edge
    bit   started     = 1'b0;
    int   phase       = 0;
    int   hs_low      = 0;
    int   vs_low      = 0;
    int   sof_cnt     = 0;
    int   first_hs    = -1;
    int   first_vs    = -1;

    // Expected pixel for visible position (h,v).
    function automatic logic [23:0] pixel(input int h, input int v);
`ifdef VGA_TEST_PATTERN_EN
        logic [23:0] c;
        case (h)
            0: c = 24'hFFFFFF;
            1: c = 24'hFFFF00;
            2: c = 24'h00FFFF;
            3: c = 24'h00FF00;
            4: c = 24'hFF00FF;
            5: c = 24'hFF0000;
            6: c = 24'h0000FF;
            default: c = 24'h000000;
        endcase
        if (v < 0) c = 24'h0;
        return c;
`else
        return {8'(h), 8'(v), 8'hA5};
`endif
    endfunction

    // Expected observation after k enabled edges since reset, with i_en=en.
    function automatic obs_t expect_at(input int kk, input logic en);
        obs_t o;
        int   h, v, d;
        logic act;
        h      = kk % 16;
        v      = (kk / 16) % 8;
        act    = (h < 8) && (v < 4);
        o.req  = act && en;
        o.x    = act ? 4'(h) : 4'd0;
        o.y    = act ? 4'(v) : 4'd0;
        o.sof  = en && (kk % 128 == 0);
        o.sync = 1'b0;
        o.vclk = 1'b1;
        d = kk - 3;
        if (d < 0) begin
            o.hs = 1'b1; o.vs = 1'b1; o.blank = 1'b0; o.rgb = 24'h0;
        end else begin
            h       = d % 16;
            v       = (d / 16) % 8;
            o.hs    = !(h >= 10 && h <= 12);
            o.vs    = !(v == 5 || v == 6);
            o.blank = (h < 8) && (v < 4);
            o.rgb   = o.blank ? pixel(h, v) : 24'h0;
        end
        return o;
    endfunction

    // One clock of stimulus; called just after a rising edge.
    task automatic cycle(input logic r, input logic en);
        exp_t e;
        int   h2, v2;
        rst  = r;
        i_en = en;
        h2 = (k - 2) % 16;
        v2 = ((k - 2) / 16) % 8;
        if (k >= 2 && h2 < 8 && v2 < 4) pix.i_rgb = {8'(h2), 8'(v2), 8'hA5};
        else                            pix.i_rgb = 24'hDEAD5A;
        if (started) begin
            e.o = expect_at(k, en);
            e.k = k;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        if (r) begin
            k       = 0;
            started = 1'b1;
        end else if (en) begin
            k++;
        end
    endtask

    task automatic check(input string name, input int got, input int want);
        vectors++;
        if (got != want) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    // Monitor: one observation per cycle, sampled on the falling edge.
    initial begin
        exp_t e;
        obs_t a;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e       = sb.pop_front();
                a.hs    = vga_hs;
                a.vs    = vga_vs;
                a.blank = vga_blank;
                a.rgb   = {vga_r, vga_g, vga_b};
                a.req   = pix.o_req;
                a.x     = pix.o_x;
                a.y     = pix.o_y;
                a.sof   = pix.o_sof;
                a.sync  = vga_sync;
                a.vclk  = vga_clk;
                vectors++;
                if (a !== e.o) begin
                    miscompares++;
                    $display("FAIL cycle k=%0d phase=%0d: got hs=%b vs=%b blank=%b rgb=%h req=%b x=%0d y=%0d sof=%b sync=%b vclk=%b, required hs=%b vs=%b blank=%b rgb=%h req=%b x=%0d y=%0d sof=%b sync=%b vclk=%b",
                             e.k, phase, a.hs, a.vs, a.blank, a.rgb, a.req, a.x, a.y, a.sof, a.sync, a.vclk,
                             e.o.hs, e.o.vs, e.o.blank, e.o.rgb, e.o.req, e.o.x, e.o.y, e.o.sof, e.o.sync, e.o.vclk);
                end
                if (phase == 1) begin
                    if (!vga_hs) hs_low++;
                    if (!vga_vs) vs_low++;
                    if (pix.o_sof) sof_cnt++;
                    if (!vga_hs && first_hs < 0) first_hs = e.k;
                    if (!vga_vs && first_vs < 0) first_vs = e.k;
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        i_en      = 1'b0;
        pix.i_rgb = 24'h0;

        // Reset with the enable low.
        cycle(1'b1, 1'b0);
        cycle(1'b1, 1'b0);

        // Free-running: two full frames after the 3-cycle pipeline fill.
        phase = 1;
        for (int i = 0; i < 259; i++) cycle(1'b0, 1'b1);
        phase = 0;
        check("hs_low_cycles", hs_low, 48);
        check("vs_low_cycles", vs_low, 64);
        check("first_hs_fall", first_hs, 13);
        check("first_vs_fall", first_vs, 83);
        check("sof_pulses", sof_cnt, 3);

        // Enable alternating 1/0: everything must hold on the idle cycles.
        phase = 2;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 140; i++) begin
            cycle(1'b0, 1'b1);
            cycle(1'b0, 1'b0);
        end

        // Reset in the middle of line 2 at column 7, then restart.
        phase = 3;
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 39; i++) cycle(1'b0, 1'b1);
        check("midframe_pos", k, 39);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        for (int i = 0; i < 150; i++) cycle(1'b0, 1'b1);

        phase = 0;
        @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 The module SHALL expose these parameters (name, default, meaning):
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch.
- H_SYNC, 96: horizontal sync width.
- H_BP, 48: horizontal back porch.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch.
- V_SYNC, 2: vertical sync width.
- V_BP, 33: vertical back porch.
- SYNC_POL, 0: asserted level of hs/vs.
- PIX_LAT, 2: cycles from o_req to i_rgb valid, range 0..7.
- COORD_W, 10: coordinate width; 2^COORD_W SHALL be >= H_TOTAL and >= V_TOTAL.
REQ-002 The module SHALL have these ports (name, direction, width, meaning):
- clk, in, 1: single clock.
- rst, in, 1: synchronous, active-high reset.
- i_en, in, 1: pixel-clock enable.
- i_rgb, in, 24: pixel data {r,g,b}.
- o_req, out, 1: pixel request.
- o_x, out, COORD_W: requested column.
- o_y, out, COORD_W: requested row.
- o_sof, out, 1: start-of-frame pulse.
- o_vga_r, out, 8: red.
- o_vga_g, out, 8: green.
- o_vga_b, out, 8: blue.
- o_vga_hs, out, 1: horizontal sync.
- o_vga_vs, out, 1: vertical sync.
- o_vga_blank, out, 1: active-low blank.
- o_vga_sync, out, 1: composite sync.
- o_vga_clk, out, 1: DAC clock.

Function
REQ-003 H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL likewise; h_cnt SHALL count 0..H_TOTAL-1 and wrap to 0; v_cnt SHALL increment only on h_cnt wrap, wrapping to 0 after V_TOTAL-1.
REQ-004 Counters, pipeline and all registered outputs SHALL advance only on cycles with i_en=1 and hold otherwise.
REQ-005 o_req SHALL be combinational, equal to (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE && i_en), with o_x=h_cnt and o_y=v_cnt; o_x/o_y SHALL be 0 outside the active area.
REQ-006 Raw hs SHALL be at SYNC_POL for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; raw vs likewise on v_cnt; otherwise at ~SYNC_POL.
REQ-007 Raw hs, vs and active SHALL pass through a PIX_LAT+1 stage enabled shift pipeline; o_vga_hs, o_vga_vs and o_vga_blank (=active) SHALL be the last stage.
REQ-008 o_vga_r/g/b SHALL register i_rgb in the cycle the matching request has aged PIX_LAT enabled cycles, and SHALL be forced to 0 when the delayed active is 0.
REQ-009 o_sof SHALL be a one-cycle pulse in the cycle with i_en=1, h_cnt=0 and v_cnt=0 (counter stage, undelayed).
REQ-010 o_vga_sync SHALL be constant 0; o_vga_clk SHALL be ~clk.

Reset
REQ-011 While rst=1 at a clk edge: h_cnt=v_cnt=0, all pipeline stages cleared to hs=vs=~SYNC_POL and active=0, o_vga_r/g/b=0, o_vga_blank=0.
REQ-012 Reset SHALL take precedence over i_en; reset mid-frame SHALL abandon the frame, and the first enabled cycle after release SHALL pulse o_sof.

Configuration
REQ-013 With VGA_TEST_PATTERN_EN defined, i_rgb SHALL be ignored and the pixel source SHALL be 8 vertical colour bars of width H_ACTIVE/8 (white, yellow, cyan, green, magenta, red, blue, black) at identical latency; without it, i_rgb SHALL be used.

Structure
REQ-014 Package vga_pkg SHALL hold the rgb struct typedef, the bar colour constants and a timing-total helper function.
REQ-015 One sub-module, vga_axis_counter (count, wrap, sync window, active flag), SHALL be instantiated twice, once per axis.

Verification
Bench parameters: H 8/2/3/3 (total 16), V 4/1/2/1 (total 8), PIX_LAT=2, SYNC_POL=0.
REQ-016 Reset, then i_en=1 held: o_vga_hs low exactly 3 of every 16 cycles; first fall 13 cycles after release.
REQ-017 Same stimulus: o_vga_vs low for 32 consecutive cycles per 128-cycle frame, starting at line 5 plus the 3-cycle delay.
REQ-018 i_en alternating 1/0: all periods double and outputs are stable during i_en=0 cycles.
REQ-019 Bench drives i_rgb={x,y,8'hA5} 2 enabled cycles after o_req: each blank-high cycle shows r=x, g=y in raster order; blank-low cycles show rgb=0.
REQ-020 rst pulsed at h_cnt=7, v_cnt=2: next cycle hs=vs=1, blank=0, rgb=0; o_sof on the first enabled cycle after release.
REQ-021 VGA_TEST_PATTERN_EN defined: pixel 0 = FFFFFF, pixel 7 = 000000 on every active line.
